// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - op_e    : Op port encodings (OP_MULT .. OP_MSUB)
//   - state_e : sequencer states (ST_IDLE, ST_MUL, ST_DIV, ST_FIX)
//   - cnt_w() : iteration counter width for a given operand width
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } state_e;

    // Wide enough to hold WIDTH itself, so a count of WIDTH-1 never wraps.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/hilo_div_step.sv
// hilo_div_step: one combinational restoring-division iteration.
//   rem_i [WIDTH:0]   partial remainder entering the step (always < divisor)
//   bit_i             next dividend bit, MSB first
//   dvs_i [WIDTH-1:0] divisor magnitude
//   rem_o [WIDTH:0]   partial remainder after the step
//   q_o               quotient bit produced by the step
module hilo_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    // One extra bit of headroom so the trial subtract never overflows.
    logic [WIDTH+1:0] shf;
    logic [WIDTH+1:0] dvs;

    assign shf   = {rem_i, bit_i};
    assign dvs   = {2'b00, dvs_i};
    assign q_o   = (shf >= dvs);
    // Restore (keep the shifted value) when the trial subtract would go negative.
    assign rem_o = q_o ? (WIDTH+1)'(shf - dvs) : shf[WIDTH:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide unit owning the HI/LO pair.
//   Clk, Rst (async, active low), Start/Op/SrcA/SrcB request one op while idle,
//   Abort cancels any in-flight op. Busy is high from the cycle after accept
//   until the result edge; Done/DivByZero pulse the cycle after HI/LO update.
//   HIOut/LOOut expose the HI and LO registers.
// Build option: define HILO_MADD_EN to accept MADD/MSUB (signed accumulate
//   into {HI,LO}); without it those encodings are ignored.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Abort,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HIOut,
    output logic [WIDTH-1:0] LOOut
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam int MUL_N = WIDTH / MUL_STEP;
    localparam int DIV_N = WIDTH;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [2:0]             op_q;
    logic                   neg_q;      // result sign: operand signs differ
    logic                   rneg_q;     // remainder sign: dividend negative
    logic                   dz_q;
    logic [WIDTH-1:0]       a_q;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]       srca_q;     // raw dividend for divide-by-zero HI
    logic [2*WIDTH-1:0]     acc_q;      // product accumulator / quotient in low half
    logic [WIDTH:0]         rem_q;
    logic [WIDTH-1:0]       hi_q, lo_q;
    logic                   busy_q, done_q, dbz_q;

    // ---- request decode ----
    logic             is_signed, sa_neg, sb_neg, madd_ok, can_acc;
    logic             mul_acc, div_acc, mt_acc;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign is_signed = (Op == OP_MULT) || (Op == OP_DIV) ||
                       (Op == OP_MADD) || (Op == OP_MSUB);
    assign sa_neg    = is_signed & SrcA[WIDTH-1];
    assign sb_neg    = is_signed & SrcB[WIDTH-1];
    assign mag_a     = sa_neg ? -SrcA : SrcA;
    assign mag_b     = sb_neg ? -SrcB : SrcB;

`ifdef HILO_MADD_EN
    assign madd_ok = (Op == OP_MADD) || (Op == OP_MSUB);
`else
    assign madd_ok = 1'b0;
`endif

    assign can_acc = Start && !Abort && (state_q == ST_IDLE);
    assign mul_acc = can_acc && ((Op == OP_MULT) || (Op == OP_MULTU) || madd_ok);
    assign div_acc = can_acc && ((Op == OP_DIV) || (Op == OP_DIVU));
    assign mt_acc  = can_acc && ((Op == OP_MTHI) || (Op == OP_MTLO));

    // ---- radix-MUL_STEP shift/add: low half holds the unconsumed multiplier ----
    logic [WIDTH+MUL_STEP-1:0] pp, psum;
    logic [2*WIDTH-1:0]        mul_nx;

    assign pp     = {{MUL_STEP{1'b0}}, a_q} * {{WIDTH{1'b0}}, acc_q[MUL_STEP-1:0]};
    assign psum   = {{MUL_STEP{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + pp;
    assign mul_nx = {psum, acc_q[WIDTH-1:MUL_STEP]};

    // ---- restoring divide: dividend bits shift out of the low half MSB first ----
    logic [WIDTH:0] rem_nx;
    logic           qbit;

    hilo_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (rem_q),
        .bit_i (acc_q[WIDTH-1]),
        .dvs_i (a_q),
        .rem_o (rem_nx),
        .q_o   (qbit)
    );

    // ---- FIX: sign correction and result placement ----
    logic [2*WIDTH-1:0] prod_s, mul_res;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic               op_is_div;

    assign op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

    always_comb begin
        prod_s  = neg_q ? -acc_q : acc_q;
        mul_res = prod_s;
        if (op_q == OP_MADD)      mul_res = {hi_q, lo_q} + prod_s;
        else if (op_q == OP_MSUB) mul_res = {hi_q, lo_q} - prod_s;
        fix_hi = mul_res[2*WIDTH-1:WIDTH];
        fix_lo = mul_res[WIDTH-1:0];
        if (op_is_div) begin
            if (dz_q) begin
                fix_lo = '1;
                fix_hi = srca_q;
            end else begin
                fix_lo = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                fix_hi = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            end
        end
    end

    // ---- sequencer ----
    always_comb begin
        state_d = state_q;
        if (Abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (mul_acc)      state_d = ST_MUL;
                         else if (div_acc) state_d = ST_DIV;
                ST_MUL:  if (cnt_q == CNT_W'(MUL_N - 1)) state_d = ST_FIX;
                ST_DIV:  if (cnt_q == CNT_W'(DIV_N - 1)) state_d = ST_FIX;
                ST_FIX:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // ---- datapath ----
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
            a_q    <= '0;
            srca_q <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (!Abort) begin
                case (state_q)
                    ST_IDLE: begin
                        cnt_q  <= '0;
                        op_q   <= Op;
                        neg_q  <= sa_neg ^ sb_neg;
                        rneg_q <= sa_neg;
                        dz_q   <= (SrcB == '0);
                        srca_q <= SrcA;
                        rem_q  <= '0;
                        if (mul_acc) begin
                            a_q   <= mag_a;
                            acc_q <= {{WIDTH{1'b0}}, mag_b};
                        end else if (div_acc) begin
                            a_q   <= mag_b;
                            acc_q <= {{WIDTH{1'b0}}, mag_a};
                        end
                        if (mt_acc && Op == OP_MTHI) hi_q <= SrcA;
                        if (mt_acc && Op == OP_MTLO) lo_q <= SrcA;
                    end
                    ST_MUL: begin
                        acc_q <= mul_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    ST_DIV: begin
                        rem_q <= rem_nx;
                        acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    ST_FIX: begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                        dbz_q  <= op_is_div & dz_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign HIOut     = hi_q;
    assign LOOut     = lo_q;

endmodule
